sort_frame_loader: RTL and testbench

- Upstream stage of the register-based sorting network.
- Accepts a serial stream of samples over a valid/ready handshake and assembles them into frames of NUM_INPUTS samples.
- Tags each sample with its arrival slot index.
- Presents each frame in parallel to the first comparison column with a one-cycle ready strobe, then holds off new input until the network has had time to produce its result.

---
 rtl/sort_frame_loader.sv | 168 ++++++++++++++++
 tb/tb_sort_frame_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_frame_loader.sv
// ---------------------------------------------------------------------------
// sort_frame_loader
//
// Front end of the register-based sorting network. Collects a serial stream
// of samples over a valid/ready handshake, packs them into a frame of
// NUM_INPUTS samples, tags every sample with the slot it arrived in, and
// hands the whole frame to the first comparison column with a one-cycle
// strobe. After the strobe the loader refuses new samples until the network
// has had NET_LATENCY cycles and has reported done.
//
// Optional feature (compile-time macro SORT_FRAME_LOADER_PAD_EN):
//   Adds input in_last. A transfer flagged in_last before the final slot
//   closes the frame early; the remaining slots are zero-filled and tagged
//   with their own slot index on the same edge.
//
// Ports:
//   clk          in   1                         system clock, rising edge
//   reset        in   1                         asynchronous, active-low reset
//   in_data      in   NETWORK_WIDTH             sample from source
//   in_valid     in   1                         in_data valid
//   in_last      in   1                         last sample of burst (PAD_EN only)
//   in_ready     out  1                         loader accepts a sample this cycle
//   net_done     in   1                         done from the last comparison column
//   net_ready    out  1                         one-cycle strobe to first column
//   frame_data   out  NUM_INPUTS*NETWORK_WIDTH  slot k at [k*NETWORK_WIDTH +: NETWORK_WIDTH]
//   frame_index  out  NUM_INPUTS*INDEX_WIDTH    slot index, same packing
//   frame_count  out  16                        frames issued since reset (wraps)
// ---------------------------------------------------------------------------
module sort_frame_loader #(
    parameter int NETWORK_WIDTH = 16,
    parameter int INDEX_WIDTH   = 3,
    parameter int NUM_INPUTS    = 8,
    parameter int NET_LATENCY   = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NETWORK_WIDTH-1:0]            in_data,
    input  logic                                in_valid,
`ifdef SORT_FRAME_LOADER_PAD_EN
    input  logic                                in_last,
`endif
    output logic                                in_ready,
    input  logic                                net_done,
    output logic                                net_ready,
    output logic [NUM_INPUTS*NETWORK_WIDTH-1:0] frame_data,
    output logic [NUM_INPUTS*INDEX_WIDTH-1:0]   frame_index,
    output logic [15:0]                         frame_count
);

    // Slot counter only needs to reach NUM_INPUTS-1 (power of two).
    localparam int CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    // Wait counter holds values 0..NET_LATENCY-1.
    localparam int WAIT_W = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;

    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NUM_INPUTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(NET_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                               r_state;
    logic [CNT_W-1:0]                     r_slot_cnt;
    logic [WAIT_W-1:0]                    r_wait_cnt;
    logic                                 r_in_ready;
    logic                                 r_net_ready;
    logic [NUM_INPUTS*NETWORK_WIDTH-1:0]  r_frame_data;
    logic [NUM_INPUTS*INDEX_WIDTH-1:0]    r_frame_index;
    logic [15:0]                          r_frame_count;

    logic                                 w_accept;
    logic                                 w_last_slot;
    logic                                 w_close;
    logic                                 w_pad;

    // A transfer needs both sides of the handshake; in_ready is only ever
    // high in FILL, but the state term keeps the intent explicit.
    assign w_accept    = in_valid && r_in_ready && (r_state == ST_FILL);
    assign w_last_slot = (r_slot_cnt == LAST_SLOT);

`ifdef SORT_FRAME_LOADER_PAD_EN
    // Early close: zero-fill the tail of the frame when the source flags
    // the end of its burst before the frame is full.
    assign w_pad   = in_last && !w_last_slot;
    assign w_close = w_last_slot || in_last;
`else
    assign w_pad   = 1'b0;
    assign w_close = w_last_slot;
`endif

    // Frame FSM. All outputs are registered here so nothing downstream sees
    // a combinational path from the inputs. net_ready and the frame count
    // are set on the edge that enters ISSUE, so they are visible exactly
    // during the ISSUE cycle. in_ready is set on the edge that enters FILL,
    // which also makes it rise on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_FILL;
            r_slot_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_in_ready    <= 1'b0;
            r_net_ready   <= 1'b0;
            r_frame_data  <= '0;
            r_frame_index <= '0;
            r_frame_count <= '0;
        end else begin
            r_net_ready <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        for (int j = 0; j < NUM_INPUTS; j++) begin
                            if (CNT_W'(j) == r_slot_cnt) begin
                                r_frame_data[j*NETWORK_WIDTH +: NETWORK_WIDTH] <= in_data;
                                r_frame_index[j*INDEX_WIDTH +: INDEX_WIDTH]    <= INDEX_WIDTH'(r_slot_cnt);
                            end else if (w_pad && (CNT_W'(j) > r_slot_cnt)) begin
                                r_frame_data[j*NETWORK_WIDTH +: NETWORK_WIDTH] <= '0;
                                r_frame_index[j*INDEX_WIDTH +: INDEX_WIDTH]    <= INDEX_WIDTH'(j);
                            end
                        end
                        if (w_close) begin
                            r_slot_cnt    <= '0;
                            r_state       <= ST_ISSUE;
                            r_in_ready    <= 1'b0;
                            r_net_ready   <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                        end else begin
                            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_ISSUE: begin
                    r_in_ready <= 1'b0;
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= ST_WAIT;
                end

                // Minimum latency first, then the network's (sticky) done.
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        if (net_done) begin
                            r_state    <= ST_FILL;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end

                default: begin
                    r_state    <= ST_FILL;
                    r_slot_cnt <= '0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign net_ready   = r_net_ready;
    assign frame_data  = r_frame_data;
    assign frame_index = r_frame_index;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_sort_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_sort_frame_loader
//
// Directed bench for sort_frame_loader with default parameters
// (16-bit samples, 3-bit index, 8 slots, network latency 3). Inputs are
// driven and outputs sampled on the falling edge. Define
// SORT_FRAME_LOADER_PAD_EN to build and exercise the padding variant.
// ---------------------------------------------------------------------------
module tb_sort_frame_loader;

    localparam int W = 16;
    localparam int IW = 3;
    localparam int N = 8;

    logic             clk;
    logic             reset;
    logic [W-1:0]     in_data;
    logic             in_valid;
`ifdef SORT_FRAME_LOADER_PAD_EN
    logic             in_last;
`endif
    logic             in_ready;
    logic             net_done;
    logic             net_ready;
    logic [N*W-1:0]   frame_data;
    logic [N*IW-1:0]  frame_index;
    logic [15:0]      frame_count;

    int tests_run;
    int tests_failed;

    logic [N*IW-1:0]  exp_idx;

    sort_frame_loader #(
        .NETWORK_WIDTH(W),
        .INDEX_WIDTH  (IW),
        .NUM_INPUTS   (N),
        .NET_LATENCY  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
`ifdef SORT_FRAME_LOADER_PAD_EN
        .in_last    (in_last),
`endif
        .in_ready   (in_ready),
        .net_done   (net_done),
        .net_ready  (net_ready),
        .frame_data (frame_data),
        .frame_index(frame_index),
        .frame_count(frame_count)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slot 0 lands in the least significant bits.
    function automatic logic [N*W-1:0] pack8(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5,
                                             input int a6, input int a7);
        logic [N*W-1:0] v;
        v = {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
        return v;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = '0;
`ifdef SORT_FRAME_LOADER_PAD_EN
        in_last  = 1'b0;
`endif
    endtask

    // Streams the first n slots of vals, holding each sample until it is
    // accepted. Returns on the falling edge whose following rising edge
    // completes the n-th transfer. last_at marks the sample carrying in_last.
    task automatic drive_frame(input logic [N*W-1:0] vals, input int n, input int last_at,
                               output int cycles, output bit ok);
        int i;
        i = 0;
        cycles = 0;
        while (i < n && cycles < 64) begin
            @(negedge clk);
            cycles++;
            in_valid = 1'b1;
            in_data  = vals[i*W +: W];
`ifdef SORT_FRAME_LOADER_PAD_EN
            in_last  = (i == last_at);
`endif
            if (in_ready) i++;
        end
        ok = (i == n);
        if (last_at > n) ok = 1'b0;
    endtask

    // Waits (bounded) until the loader is back in FILL.
    task automatic wait_ready(output bit ok);
        int c;
        c = 0;
        @(negedge clk);
        while (!in_ready && c < 40) begin
            @(negedge clk);
            c++;
        end
        ok = in_ready;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        net_done = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready);
        end
        tests_run++;
        if (net_ready !== 1'b0 || frame_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl got net_ready=%b count=%0d want 0/0", net_ready, frame_count);
        end
        tests_run++;
        if (frame_data !== '0 || frame_index !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_frame got data=%h index=%h want 0", frame_data, frame_index);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_single_frame();
        logic [N*W-1:0] vals;
        int cycles;
        bit ok;
        vals = pack8(8, 3, 5, 1, 7, 2, 6, 4);
        drive_frame(vals, 8, -1, cycles, ok);
        tests_run++;
        if (!ok || cycles != 8) begin
            tests_failed++;
            $display("[TB] FAIL single_fill_cycles got=%0d ok=%b want=8", cycles, ok);
        end
        @(negedge clk);
        idle_inputs();
        tests_run++;
        if (net_ready !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_strobe got net_ready=%b in_ready=%b want 1/0", net_ready, in_ready);
        end
        tests_run++;
        if (frame_data !== vals) begin
            tests_failed++;
            $display("[TB] FAIL single_data got=%h want=%h", frame_data, vals);
        end
        tests_run++;
        if (frame_index !== exp_idx) begin
            tests_failed++;
            $display("[TB] FAIL single_index got=%h want=%h", frame_index, exp_idx);
        end
        tests_run++;
        if (frame_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_count got=%0d want=1", frame_count);
        end
        @(negedge clk);
        tests_run++;
        if (net_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_pulse_width got=%b want=0", net_ready);
        end
    endtask

    task automatic test_net_done_gate();
        logic [N*W-1:0] vals;
        int cycles;
        int ready_seen;
        int data_moved;
        bit ok;
        @(negedge clk);
        reset    = 1'b0;
        net_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vals = pack8(8, 3, 5, 1, 7, 2, 6, 4);
        drive_frame(vals, 8, -1, cycles, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL gate_fill_timeout got=%0d transfers_ok=%b want ok", cycles, ok);
        end
        @(negedge clk);
        idle_inputs();
        ready_seen = 0;
        data_moved = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) ready_seen++;
            if (frame_data !== vals) data_moved++;
        end
        tests_run++;
        if (ready_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL gate_hold_ready got=%0d cycles high want=0", ready_seen);
        end
        tests_run++;
        if (data_moved != 0) begin
            tests_failed++;
            $display("[TB] FAIL gate_hold_data got=%0d unstable cycles want=0", data_moved);
        end
        net_done = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL gate_release got in_ready=%b want=1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] va;
        logic [N*W-1:0] vb;
        logic [N*W-1:0] snap;
        logic [N*W-1:0] got_a;
        logic [N*W-1:0] got_b;
        int p0;
        int p1;
        int i;
        int unstable;
        logic [15:0] cnt_b;
        va = pack8(100, 200, 300, 400, 500, 600, 700, 800);
        vb = pack8(11, 22, 33, 44, 55, 66, 77, 88);
        p0 = -1;
        p1 = -1;
        i = 0;
        unstable = 0;
        snap = '0;
        got_a = '0;
        got_b = '0;
        cnt_b = '0;
        for (int c = 0; c < 60 && p1 < 0; c++) begin
            @(negedge clk);
            if (net_ready) begin
                if (p0 < 0) begin
                    p0 = c;
                    got_a = frame_data;
                end else begin
                    p1 = c;
                    got_b = frame_data;
                    cnt_b = frame_count;
                end
                snap = frame_data;
            end else if (!in_ready && p0 >= 0) begin
                if (frame_data !== snap) unstable++;
            end
            if (i < 16) begin
                in_valid = 1'b1;
                in_data  = (i < 8) ? va[i*W +: W] : vb[(i-8)*W +: W];
                if (in_ready) i++;
            end else begin
                idle_inputs();
            end
        end
        idle_inputs();
        tests_run++;
        if (p0 < 0 || p1 < 0 || (p1 - p0) != 12) begin
            tests_failed++;
            $display("[TB] FAIL b2b_period got p0=%0d p1=%0d want spacing 12", p0, p1);
        end
        tests_run++;
        if (got_a !== va || got_b !== vb) begin
            tests_failed++;
            $display("[TB] FAIL b2b_data got a=%h b=%h want a=%h b=%h", got_a, got_b, va, vb);
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold got=%0d unstable cycles want=0", unstable);
        end
        tests_run++;
        if (cnt_b !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count got=%0d want=3", cnt_b);
        end
    endtask

    task automatic test_async_reset();
        logic [N*W-1:0] vals;
        int cycles;
        bit ok;
        vals = pack8(41, 42, 43, 44, 45, 46, 47, 48);
        drive_frame(vals, 5, -1, cycles, ok);
        @(negedge clk);
        idle_inputs();
        tests_run++;
        if (!ok || frame_data[4*W +: W] !== W'(45)) begin
            tests_failed++;
            $display("[TB] FAIL areset_partial got slot4=%0d ok=%b want=45", frame_data[4*W +: W], ok);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (frame_data !== '0 || frame_index !== '0 || frame_count !== 16'd0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL areset_clear got data=%h index=%h count=%0d ready=%b want all 0",
                     frame_data, frame_index, frame_count, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        vals = pack8(9, 8, 7, 6, 5, 4, 3, 2);
        drive_frame(vals, 8, -1, cycles, ok);
        @(negedge clk);
        idle_inputs();
        tests_run++;
        if (!ok || net_ready !== 1'b1 || frame_data !== vals || frame_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL areset_next_frame got ok=%b strobe=%b data=%h count=%0d want 1/1/%h/1",
                     ok, net_ready, frame_data, frame_count, vals);
        end
    endtask

    task automatic test_valid_toggle();
        logic [N*W-1:0] vals;
        int j;
        int pulses;
        bit ok;
        vals = pack8(1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000);
        wait_ready(ok);
        j = 0;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (net_ready) pulses++;
            in_valid = ((k % 2) == 0);
            in_data  = in_valid ? vals[j*W +: W] : 16'hBEEF;
            if (in_valid && in_ready) j++;
        end
        @(negedge clk);
        idle_inputs();
        tests_run++;
        if (!ok || pulses != 1 || j != 8) begin
            tests_failed++;
            $display("[TB] FAIL toggle_strobe got pulses=%0d transfers=%0d ok=%b want 1/8", pulses, j, ok);
        end
        tests_run++;
        if (frame_data !== vals || frame_count !== 16'd2) begin
            tests_failed++;
            $display("[TB] FAIL toggle_data got data=%h count=%0d want=%h/2", frame_data, frame_count, vals);
        end
    endtask

`ifdef SORT_FRAME_LOADER_PAD_EN
    task automatic test_pad();
        logic [N*W-1:0] vals;
        logic [N*W-1:0] next;
        int cycles;
        bit ok;
        bit ok2;
        vals = pack8(9, 9, 9, 0, 0, 0, 0, 0);
        wait_ready(ok);
        drive_frame(vals, 3, 2, cycles, ok2);
        @(negedge clk);
        idle_inputs();
        tests_run++;
        if (!ok || !ok2 || net_ready !== 1'b1 || frame_count !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL pad_strobe got strobe=%b count=%0d ok=%b/%b want 1/3", net_ready, frame_count, ok, ok2);
        end
        tests_run++;
        if (frame_data !== vals || frame_index !== exp_idx) begin
            tests_failed++;
            $display("[TB] FAIL pad_frame got data=%h index=%h want=%h/%h", frame_data, frame_index, vals, exp_idx);
        end
        next = pack8(21, 22, 23, 24, 25, 26, 27, 28);
        wait_ready(ok);
        drive_frame(next, 8, -1, cycles, ok2);
        @(negedge clk);
        idle_inputs();
        tests_run++;
        if (!ok || !ok2 || frame_data !== next || frame_count !== 16'd4) begin
            tests_failed++;
            $display("[TB] FAIL pad_next_frame got data=%h count=%0d want=%h/4", frame_data, frame_count, next);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int k = 0; k < N; k++) exp_idx[k*IW +: IW] = IW'(k);
        test_reset();
        test_single_frame();
        test_net_done_gate();
        test_back_to_back();
        test_async_reset();
        test_valid_toggle();
`ifdef SORT_FRAME_LOADER_PAD_EN
        test_pad();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
